// File: rtl/dff_response_checker.sv
// dff_response_checker: drives an LFSR pattern into an external flip-flop and counts response errors.
module dff_response_checker #(
  parameter int          PATTERN_LEN = 64,
  parameter int          ERR_W       = 8,
  parameter logic [7:0]  SEED        = 8'hA5
) (
  input  logic             clk,
  input  logic             rst_l,
  input  logic             start,
  input  logic             q_in,
  input  logic             qbar_in,
  output logic             d_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t r_state, w_next;
  logic [7:0]       r_lfsr, r_idx;
  logic             r_exp_bit, r_exp_valid;
  logic [ERR_W-1:0] r_err;
  logic             w_load, w_last, w_fail;
  assign w_load = (r_state == IDLE || r_state == DONE) && start;
  assign w_last = r_idx == 8'(PATTERN_LEN - 1);
  // Case equality so X/Z on the flip-flop outputs counts as a failure
  assign w_fail = r_exp_valid && !((q_in === r_exp_bit) && (qbar_in === ~q_in));
  always_comb begin
    w_next    = w_load ? RUN : (r_state == RUN && w_last) ? DRAIN : (r_state == DRAIN) ? DONE : r_state;
    d_out     = (r_state == RUN) && r_lfsr[0];
    busy      = r_state == RUN || r_state == DRAIN;
    done      = r_state == DONE;
    pass      = done && r_err == '0;
    err_count = r_err;
  end
  always_ff @(posedge clk or negedge rst_l)
    if (!rst_l) r_state <= IDLE;
    else r_state <= w_next;
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_lfsr      <= SEED;
      r_idx       <= '0;
      r_exp_bit   <= 1'b0;
      r_exp_valid <= 1'b0;
      r_err       <= '0;
    end else if (w_load) begin
      r_lfsr      <= SEED;
      r_idx       <= '0;
      r_exp_valid <= 1'b0;
      r_err       <= '0;
    end else begin
      if (w_fail && r_err != '1) r_err <= r_err + 1'b1;
      if (r_state == RUN) begin
        r_exp_bit   <= r_lfsr[0];
        r_exp_valid <= 1'b1;
        r_lfsr      <= {r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[4], r_lfsr[7:1]};
        r_idx       <= r_idx + 8'd1;
      end else if (r_state == DRAIN) begin
        r_exp_valid <= 1'b0;
      end
    end
  end
endmodule
